// File: rtl/udm_gpio_regs.sv
// udm_gpio_regs: GPIO register slave for the UDM debug bus.
// OUT_CH output registers with set/clear/toggle aliases, IN_CH
// synchronised inputs with sticky edge flags and a maskable irq.
// Ports: clk_i/rst_i (sync, active-high), bus_* UDM slave port
// (ack combinational, resp/rdata one cycle after a read),
// gpio_out_bo packed output channels, gpio_in_bi async pins, irq_o.
module udm_gpio_regs #(
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_0000,
  parameter int               OUT_CH      = 2,
  parameter int               IN_CH       = 2,
  parameter int               OUT_W       = 16,
  parameter int               IN_W        = 16,
  parameter logic [OUT_W-1:0] OUT_RST     = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    bus_req_i,
  input  logic                    bus_we_i,
  input  logic [31:0]             bus_addr_bi,
  input  logic [3:0]              bus_be_bi,
  input  logic [31:0]             bus_wdata_bi,
  output logic                    bus_ack_o,
  output logic                    bus_resp_o,
  output logic [31:0]             bus_rdata_bo,
  output logic [OUT_CH*OUT_W-1:0] gpio_out_bo,
  input  logic [IN_CH*IN_W-1:0]   gpio_in_bi,
  output logic                    irq_o
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int AW      = $clog2(ARM_MAX + 1);

  logic [3:0]       ch;
  logic [2:0]       grp;
  logic             in_win;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      bmask;
  logic [31:0]      wd;
  logic [OUT_W-1:0] m_o;
  logic [OUT_W-1:0] d_o;
  logic [IN_W-1:0]  m_i;
  logic [IN_W-1:0]  d_i;

  logic [OUT_W-1:0] out_q  [OUT_CH];
  logic [OUT_W-1:0] out_d  [OUT_CH];
  logic [IN_W-1:0]  sync_q [IN_CH][SYNC_STAGES];
  logic [IN_W-1:0]  prev_q [IN_CH];
  logic [IN_W-1:0]  edge_q [IN_CH];
  logic [IN_W-1:0]  edge_d [IN_CH];
  logic [IN_W-1:0]  ien_q  [IN_CH];
  logic [IN_W-1:0]  ien_d  [IN_CH];
  logic [IN_CH-1:0] istat;

  logic [AW-1:0]    arm_q;
  logic             armed;
  logic [31:0]      rd_val;
  logic             resp_q;
  logic [31:0]      rdata_q;
  logic             irq_q;
  logic             unused_ok;

  assign ch     = bus_addr_bi[5:2];
  assign grp    = bus_addr_bi[8:6];
  assign in_win = bus_addr_bi[31:9] == BASE_ADDR[31:9];
  assign wr_en  = bus_req_i & bus_we_i & in_win;
  assign rd_en  = bus_req_i & ~bus_we_i;

  assign bmask = {{8{bus_be_bi[3]}}, {8{bus_be_bi[2]}},
                  {8{bus_be_bi[1]}}, {8{bus_be_bi[0]}}};
  assign wd    = bus_wdata_bi & bmask;
  assign m_o   = bmask[OUT_W-1:0];
  assign d_o   = wd[OUT_W-1:0];
  assign m_i   = bmask[IN_W-1:0];
  assign d_i   = wd[IN_W-1:0];

  // Edge flags stay masked until the sync chain has flushed its
  // reset zeros, so pins already high at reset do not flag.
  assign armed = arm_q == AW'(ARM_MAX);

  assign unused_ok = ^{bus_addr_bi[1:0], bmask, wd};

  assign bus_ack_o    = bus_req_i;
  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign irq_o        = irq_q;

  always_comb begin
    gpio_out_bo = '0;
    for (int k = 0; k < OUT_CH; k++) begin
      gpio_out_bo[k*OUT_W +: OUT_W] = out_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < OUT_CH; k++) begin
      out_d[k] = out_q[k];
      if (wr_en && ch == 4'(k)) begin
        unique case (1'b1)
          grp == 3'd0: out_d[k] = (out_q[k] & ~m_o) | d_o;
          grp == 3'd1: out_d[k] = out_q[k] | d_o;
          grp == 3'd2: out_d[k] = out_q[k] & ~d_o;
          grp == 3'd3: out_d[k] = out_q[k] ^ d_o;
          default: ;
        endcase
      end
    end
  end

  // Set beats clear: the detected change is OR-ed in after W1C.
  always_comb begin
    for (int k = 0; k < IN_CH; k++) begin
      edge_d[k] = edge_q[k];
      ien_d[k]  = ien_q[k];
      if (wr_en && ch == 4'(k) && grp == 3'd5) begin
        edge_d[k] = edge_q[k] & ~d_i;
      end
      if (wr_en && ch == 4'(k) && grp == 3'd6) begin
        ien_d[k] = (ien_q[k] & ~m_i) | d_i;
      end
      if (armed) begin
        edge_d[k] = edge_d[k]
                  | (sync_q[k][SYNC_STAGES-1] ^ prev_q[k]);
      end
      istat[k] = |(edge_q[k] & ien_q[k]);
    end
  end

  always_comb begin
    rd_val = '0;
    if (in_win) begin
      unique case (1'b1)
        grp < 3'd4: begin
          for (int k = 0; k < OUT_CH; k++) begin
            if (ch == 4'(k)) rd_val = 32'(out_q[k]);
          end
        end
        grp == 3'd4: begin
          for (int k = 0; k < IN_CH; k++) begin
            if (ch == 4'(k)) begin
              rd_val = 32'(sync_q[k][SYNC_STAGES-1]);
            end
          end
        end
        grp == 3'd5: begin
          for (int k = 0; k < IN_CH; k++) begin
            if (ch == 4'(k)) rd_val = 32'(edge_q[k]);
          end
        end
        grp == 3'd6: begin
          for (int k = 0; k < IN_CH; k++) begin
            if (ch == 4'(k)) rd_val = 32'(ien_q[k]);
          end
        end
        grp == 3'd7: begin
          if (ch == 4'd0) rd_val = 32'(istat);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < OUT_CH; k++) begin
        out_q[k] <= OUT_RST;
      end
      for (int k = 0; k < IN_CH; k++) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[k][s] <= '0;
        end
        prev_q[k] <= '0;
        edge_q[k] <= '0;
        ien_q[k]  <= '0;
      end
      arm_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (!armed) arm_q <= arm_q + AW'(1);
      for (int k = 0; k < OUT_CH; k++) begin
        out_q[k] <= out_d[k];
      end
      for (int k = 0; k < IN_CH; k++) begin
        sync_q[k][0] <= gpio_in_bi[k*IN_W +: IN_W];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[k][s] <= sync_q[k][s-1];
        end
        prev_q[k] <= sync_q[k][SYNC_STAGES-1];
        edge_q[k] <= edge_d[k];
        ien_q[k]  <= ien_d[k];
      end
      resp_q  <= rd_en;
      rdata_q <= rd_en ? rd_val : '0;
      irq_q   <= |istat;
    end
  end

endmodule

// File: doc/udm_gpio_regs.md
# udm_gpio_regs

Parametrised GPIO register slave for the UDM debug bus, the generalised successor of the single-LED/single-switch board glue. It provides OUT_CH output registers and IN_CH synchronised input ports, with set/clear/toggle aliases, byte-enable writes, sticky edge detection and a maskable interrupt. It sits directly on the udm_memsplit bus port in a board top level, between the UART debug master and the board pins.

## Interface
- BASE_ADDR, 32'h0000_0000: base of the 512-byte window; must be 512-byte aligned.
- OUT_CH, 2: output channels, 1..8.
- IN_CH, 2: input channels, 1..8.
- OUT_W, 16: bits per output channel, 1..32.
- IN_W, 16: bits per input channel, 1..32.
- OUT_RST, 0: reset value of every output register (OUT_W bits).
- SYNC_STAGES, 2: input synchroniser depth, at least 2.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- bus_req_i  in  1  request strobe.
- bus_we_i  in  1  1 = write.
- bus_addr_bi  in  32  byte address.
- bus_be_bi  in  4  byte enables.
- bus_wdata_bi  in  32  write data.
- bus_ack_o  out  1  request accepted.
- bus_resp_o  out  1  read data valid.
- bus_rdata_bo  out  32  read data.
- gpio_out_bo  out  OUT_CH*OUT_W  channel k at [k*OUT_W +: OUT_W].
- gpio_in_bi  in  IN_CH*IN_W  asynchronous pins; channel k at [k*IN_W +: IN_W].
- irq_o  out  1  registered interrupt.

## Operation
- Decode: the block is selected when addr[31:9] == BASE_ADDR[31:9]. addr[1:0] is ignored. Channel k = addr[5:2]. Offset group = addr[8:6].
- Register map (byte offsets):
  - 0x000+4k OUT[k]: read/write.
  - 0x040+4k SET[k]: OUT |= wdata.
  - 0x080+4k CLR[k]: OUT &= ~wdata.
  - 0x0C0+4k TGL[k]: OUT ^= wdata.
  - 0x100+4k IN[k]: read-only, synchronised value.
  - 0x140+4k EDGE[k]: sticky any-change flags, write-1-to-clear.
  - 0x180+4k IEN[k]: interrupt enable, read/write.
  - 0x1C0 ISTAT: read-only; bit k = |(EDGE[k] & IEN[k]).
- Reads of SET, CLR and TGL return OUT[k].
- Unmapped accesses are any of: k >= OUT_CH for groups 0–3; k >= IN_CH for groups 4–6; nonzero k in group 7; or an address outside the window.
  - Unmapped writes are ignored.
  - Unmapped reads still respond, with rdata = 0.
- Byte enables: be[i] gates bits [8i+7:8i] for OUT, SET, CLR, TGL, EDGE (W1C) and IEN. Bits in disabled bytes are unchanged.
- Width rules:
  - Bits at or above OUT_W (or IN_W) read as 0 and are ignored on write.
  - ISTAT bits at or above IN_CH read as 0.
- Synchroniser: SYNC_STAGES-flop chain per bit, reset to 0.
- Edge detection: sync output is compared with its previous value; any differing bit sets EDGE.
- Edge arming:
  - After reset, a counter holds edge detection disabled for SYNC_STAGES+1 cycles, so a pin already high at reset does not flag.
  - The counter saturates and stays armed until the next reset.
- If an edge and a W1C hit the same bit in the same cycle, set wins (the flag stays 1).
- irq_o is registered |ISTAT.
- Reset values:
  - OUT = OUT_RST; EDGE = 0; IEN = 0; sync chain = 0; arm counter = 0.
  - bus_resp_o = 0; bus_rdata_bo = 0; irq_o = 0.
  - Reset asserted mid-transaction drops any pending response: resp is 0 in the cycle after reset is sampled.

## Timing
- bus_ack_o = bus_req_i, combinational. Every request is accepted in the same cycle; no wait states.
- Write: the register updates on the clock edge where req & we is sampled. gpio_out_bo shows the new value in the next cycle.
- Read: bus_resp_o is high for exactly one cycle, the cycle after req & !we. bus_rdata_bo is valid in that cycle and 0 whenever resp is 0.
- Back-to-back reads produce back-to-back resp pulses.
- A read in the cycle immediately after a write to the same register returns the written value.
- Pin-to-IN latency: a pin change is visible in IN after SYNC_STAGES edges.
- EDGE sets one cycle after the sync output changes.
- irq_o rises one cycle after EDGE & IEN becomes nonzero. It falls one cycle after the W1C or IEN clear.

## Test plan
- Reset with OUT_RST=16'hA5A5: gpio_out_bo = {2{16'hA5A5}}, resp=0, irq_o=0, and a read of 0x000 returns 32'h0000A5A5.
- Byte-enable and aliases:
  - Write 0x000 = 32'h1234 with be=4'b0001: OUT[0] = 16'hA534.
  - SET 0x040 = 16'h0F00 gives 16'hAF34.
  - CLR 0x080 = 16'h0004 gives 16'hAF30.
  - TGL 0x0C0 = 16'hFFFF gives 16'h50CF.
  - Each result is visible on gpio_out_bo one cycle after the write.
- Input sync/edge/IRQ:
  - Set IEN[1] = 16'h0001, then toggle pin bit 0 of channel 1.
  - IN[1] reads 1 after SYNC_STAGES cycles; EDGE[1] = 1; ISTAT = 2'b10; irq_o = 1.
  - W1C EDGE[1] = 1 drops irq_o one cycle later.
- Simultaneous edge and W1C on the same bit in the same cycle: EDGE stays 1.
- Pins held at 16'hFFFF through reset release: EDGE reads 0 after arming.
- Unmapped accesses:
  - Read 0x00C (k=3 > OUT_CH) returns resp=1, rdata=0.
  - Read of BASE_ADDR+0x200 returns resp=1, rdata=0.
  - Writes to both addresses change nothing.
  - Back-to-back reads of 0x000 and 0x100 give resp high for 2 consecutive cycles.
